instruction_decoder: RTL

INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

---
 rtl/instruction_decoder.sv | 107 ++++++++++
 1 files changed

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - zero-latency opcode decode with zero flag and interrupt context.
// Define DECODER_ISR_CTX_EN to build the z_flag save/restore and ISR tracking FSM.
module instruction_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pm_data,
    input  logic       interrupt,
    input  logic       alu_zero,
    output logic       jmp,
    output logic       jmp_nz,
    output logic       dont_jmp,
    output logic [3:0] jmp_addr,
    output logic       NOPC8,
    output logic       NOPCF,
    output logic       NOPD8,
    output logic       NOPDF,
    output logic       z_flag,
    output logic       isr_active,
    output logic [3:0] isr_count
);

    logic       alu_op;
    logic       z_d;
    logic       int_accept;
    logic       z_flag_q;
    logic [3:0] isr_count_q;
    logic [3:0] isr_count_d;

    assign alu_op   = (pm_data[7:6] == 2'b10);
    assign jmp      = (pm_data[7:4] == 4'hE);
    assign jmp_nz   = (pm_data[7:4] == 4'hF);
    assign jmp_addr = pm_data[3:0];
    assign NOPC8    = (pm_data == 8'hC8);
    assign NOPCF    = (pm_data == 8'hCF);
    assign NOPD8    = (pm_data == 8'hD8);
    assign NOPDF    = (pm_data == 8'hDF);

    // Return-from-interrupt outranks a simultaneous interrupt request.
    assign int_accept  = interrupt & ~NOPC8;
    assign z_d         = alu_op ? alu_zero : z_flag_q;
    assign isr_count_d = (int_accept && (isr_count_q != 4'hF)) ? isr_count_q + 4'd1 : isr_count_q;

    assign z_flag    = z_flag_q;
    assign dont_jmp  = z_flag_q;
    assign isr_count = isr_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            isr_count_q <= 4'd0;
        end else begin
            isr_count_q <= isr_count_d;
        end
    end

`ifdef DECODER_ISR_CTX_EN
    typedef enum logic {IDLE = 1'b0, ISR = 1'b1} isr_state_t;

    isr_state_t state_q;
    logic       z_save_q;

    // Single save slot: a nested interrupt overwrites the earlier context.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            z_save_q <= 1'b0;
            z_flag_q <= 1'b0;
        end else begin
            if (int_accept) begin
                z_save_q <= z_d;
            end
            case (state_q)
                IDLE: begin
                    z_flag_q <= z_d;
                    if (int_accept) begin
                        state_q <= ISR;
                    end
                end
                ISR: begin
                    if (NOPC8) begin
                        z_flag_q <= z_save_q;
                        state_q  <= IDLE;
                    end else begin
                        z_flag_q <= z_d;
                    end
                end
                default: begin
                    z_flag_q <= z_d;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign isr_active = (state_q == ISR);
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_flag_q <= 1'b0;
        end else begin
            z_flag_q <= z_d;
        end
    end

    assign isr_active = 1'b0;
`endif

endmodule
